// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the capture (RX) and playback (TX) sides:
// default geometry, FSM state encodings and the header pattern.
package i2s_pkg;

   localparam int unsigned I2S_AUDIO_DW  = 32;               // bits per channel
   localparam int unsigned I2S_BPW       = I2S_AUDIO_DW / 4; // bytes per stereo word
   localparam int unsigned I2S_HEAD_SIZE = 256;              // header bytes
   localparam int unsigned I2S_DATA_SIZE = 256;              // payload bytes per frame
   localparam int unsigned I2S_ADDR_W    = 14;               // capture memory address width
   localparam int unsigned I2S_CNT_W     = 16;               // header/payload byte counters

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEAD = 2'd1,
      ST_DATA = 2'd2
   } i2s_state_e;

   // Header byte i carries the low 8 bits of its own index.
   function automatic logic [7:0] hdr_byte(input logic [I2S_CNT_W-1:0] i);
      return 8'(i & 16'h00FF);
   endfunction

endpackage

// File: rtl/i2s_word_unpack.sv
// Word-to-byte unpacker: latches one BPW-byte word and emits it LSB byte
// first, one byte per cycle, starting the cycle after i_load.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   i_clear       abort any emission in progress
//   i_load        latch i_word (ignored while i_clear is high)
//   i_word        word to unpack, byte 0 = i_word[7:0]
//   o_byte        current byte (registered)
//   o_valid       o_byte is valid this cycle
//   o_last        o_byte is the final byte of the word
//   o_busy        an emission is in progress (same as o_valid)
module i2s_word_unpack
   import i2s_pkg::*;
#(
   parameter int unsigned BPW = I2S_BPW
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [8*BPW-1:0] i_word,
   output logic [7:0]       o_byte,
   output logic             o_valid,
   output logic             o_last,
   output logic             o_busy
);

   localparam int unsigned WW = 8 * BPW;
   localparam int unsigned KW = (BPW > 1) ? $clog2(BPW) : 1;

   logic [WW-1:0] r_word;
   logic [KW-1:0] r_k;
   logic [7:0]    r_byte;
   logic          r_valid;
   logic          r_last;

   // Byte shifter; r_last is precomputed so the final byte is flagged in its own cycle.
   always_ff @(posedge clk) begin
      if (!reset_n || i_clear) begin
         r_word  <= '0;
         r_k     <= '0;
         r_byte  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else if (i_load) begin
         r_byte  <= i_word[7:0];
         r_word  <= i_word >> 8;
         r_k     <= '0;
         r_valid <= 1'b1;
         r_last  <= (BPW == 1);
      end else if (r_valid) begin
         if (r_last) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end else begin
            r_byte <= r_word[7:0];
            r_word <= r_word >> 8;
            r_k    <= r_k + KW'(1);
            r_last <= ((32'(r_k) + 32'd2) == BPW);
         end
      end
   end

   assign o_byte  = r_byte;
   assign o_valid = r_valid;
   assign o_last  = r_last;
   assign o_busy  = r_valid;

endmodule

// File: rtl/i2s_rx_capture.sv
// I2S capture: hunts for the counting 256-byte header in the incoming
// stereo words, then unpacks the payload bytes LSB-first into the capture
// RAM, and repeats header/payload continuously.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   start          abort and re-arm the header hunt; clears flags
//   data_in        stereo word from the RX core, byte 0 = data_in[7:0]
//   data_valid     data_in strobe
//   mem_addr       capture byte address
//   mem_wdata      capture byte
//   mem_we         capture write strobe
//   busy           hunting a header or capturing payload
//   frame_done     pulse after the last payload byte of a frame
//   header_err     sticky header mismatch
//   overrun        sticky word-dropped-while-unpacking
module i2s_rx_capture
   import i2s_pkg::*;
#(
   parameter int unsigned AUDIO_DW  = I2S_AUDIO_DW,
   parameter int unsigned HEAD_SIZE = I2S_HEAD_SIZE,
   parameter int unsigned DATA_SIZE = I2S_DATA_SIZE,
   parameter int unsigned ADDR_W    = I2S_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [2*AUDIO_DW-1:0] data_in,
   input  logic                  data_valid,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [7:0]            mem_wdata,
   output logic                  mem_we,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  header_err,
   output logic                  overrun
);

   localparam int unsigned BPW   = AUDIO_DW / 4;
   localparam int unsigned CNT_W = I2S_CNT_W;

   i2s_state_e        r_state;
   logic [CNT_W-1:0]  r_head_cnt;
   logic [CNT_W-1:0]  r_data_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic              r_busy;
   logic              r_frame_done;
   logic              r_header_err;
   logic              r_overrun;

   logic              w_hdr_ok;
   logic              w_load;
   logic [7:0]        w_unp_byte;
   logic              w_unp_valid;
   logic              w_unp_last;
   logic              w_unp_busy;

   // All header bytes of the word are checked in parallel against the running index.
   always_comb begin
      w_hdr_ok = 1'b1;
      for (int k = 0; k < int'(BPW); k++) begin
         if (data_in[8*k +: 8] != hdr_byte(r_head_cnt + CNT_W'(k))) begin
            w_hdr_ok = 1'b0;
         end
      end
   end

   assign w_load = (r_state == ST_DATA) && data_valid && !w_unp_busy;

   i2s_word_unpack #(
      .BPW (BPW)
   ) u_unpack (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clear (start),
      .i_load  (w_load),
      .i_word  (data_in),
      .o_byte  (w_unp_byte),
      .o_valid (w_unp_valid),
      .o_last  (w_unp_last),
      .o_busy  (w_unp_busy)
   );

   // Frame FSM, counters, address generator and sticky flags.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_head_cnt   <= '0;
         r_data_cnt   <= '0;
         r_addr       <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_header_err <= 1'b0;
         r_overrun    <= 1'b0;
      end else if (start) begin
         // start wins over a same-cycle data_valid; that word is dropped
         r_state      <= ST_HEAD;
         r_head_cnt   <= '0;
         r_data_cnt   <= '0;
         r_addr       <= '0;
         r_busy       <= 1'b1;
         r_frame_done <= 1'b0;
         r_header_err <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;

         if (data_valid && w_unp_busy) begin
            r_overrun <= 1'b1;
         end

         // Address follows the unpacker: base on load, +1 per non-final byte.
         if (w_load) begin
            r_addr <= r_data_cnt[ADDR_W-1:0];
         end else if (w_unp_valid && !w_unp_last) begin
            r_addr <= r_addr + ADDR_W'(1);
         end

         case (r_state)
            ST_IDLE: begin
               r_busy <= 1'b0;
            end
            ST_HEAD: begin
               if (data_valid) begin
                  if (!w_hdr_ok) begin
                     r_header_err <= 1'b1;
                     r_head_cnt   <= '0;
                  end else if ((32'(r_head_cnt) + BPW) == HEAD_SIZE) begin
                     r_state    <= ST_DATA;
                     r_head_cnt <= '0;
                  end else begin
                     r_head_cnt <= r_head_cnt + CNT_W'(BPW);
                  end
               end
            end
            ST_DATA: begin
               if (w_unp_last) begin
                  if ((32'(r_data_cnt) + BPW) == DATA_SIZE) begin
                     r_state      <= ST_HEAD;
                     r_data_cnt   <= '0;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_data_cnt <= r_data_cnt + CNT_W'(BPW);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_addr   = r_addr;
   assign mem_wdata  = w_unp_byte;
   assign mem_we     = w_unp_valid;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign header_err = r_header_err;
   assign overrun    = r_overrun;

endmodule
